fb_read_master: RTL and testbench

Avalon-MM pipelined read master that streams one frame of pixel words out of the SRAM frame buffer into a show-ahead pixel FIFO for the VGA output path. It is the consumer-side counterpart of the cellular-automaton write path: it sits between the arbitration point in front of `avalon_sram_controller` and the pixel-domain display logic, and runs entirely in the `sys_clk` domain. Flow control reserves FIFO space for every outstanding read, so the FIFO can never overflow.

---
 rtl/fb_read_master_if.sv | 24 ++
 rtl/fb_read_master.sv | 135 +++++++++++++
 tb/tb_fb_read_master.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_read_master_if.sv
// Avalon-MM read port plus show-ahead pixel stream of fb_read_master.
// master: the reader's view; slave: the SRAM/arbiter and pixel-consumer view.
interface fb_read_master_if #(
    parameter int AW = 18,
    parameter int DW = 16
);
    logic          avn_read;
    logic [AW-1:0] avn_address;
    logic          avn_waitrequest;
    logic [DW-1:0] avn_readdata;
    logic [DW-1:0] pix_data;
    logic          pix_valid;
    logic          pix_ready;

    modport master (
        output avn_read, avn_address, pix_data, pix_valid,
        input  avn_waitrequest, avn_readdata, pix_ready
    );

    modport slave (
        input  avn_read, avn_address, pix_data, pix_valid,
        output avn_waitrequest, avn_readdata, pix_ready
    );
endinterface

// File: rtl/fb_read_master.sv
// Streams FRAME_WORDS SRAM words into a show-ahead FIFO; a read issues only with FIFO space reserved for it.
// Macro FB_READER_STATUS_EN adds sticky underflow/overrun flags with status_clr.
module fb_read_master #(
    parameter int AVN_AW       = 18,
    parameter int AVN_DW       = 16,
    parameter int FRAME_WORDS  = 76800,
    parameter int BASE_ADDR    = 0,
    parameter int FIFO_DEPTH   = 16,
    parameter int READ_LATENCY = 2
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic frame_start,
    output logic frame_busy,
`ifdef FB_READER_STATUS_EN
    input  logic status_clr,
    output logic underflow,
    output logic overrun,
`endif
    fb_read_master_if.master bus
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int IW = $clog2(FRAME_WORDS + 1);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;

    state_e                  state_q, state_d;
    logic [AVN_AW-1:0]       addr_q, addr_d;
    logic [IW-1:0]           issued_q, issued_d;
    logic [CW-1:0]           outst_q, outst_d;
    logic [CW-1:0]           count_q, count_d;
    logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [READ_LATENCY-1:0] rvld_q;
    logic [AVN_DW-1:0]       mem_q [FIFO_DEPTH];

    logic space_ok, rd_req, accept, push, pop, pix_vld;

    // Outstanding reads count against FIFO space so a return always has a slot.
    assign space_ok = ((CW+1)'(count_q) + (CW+1)'(outst_q)) < (CW+1)'(FIFO_DEPTH);
    assign accept   = rd_req & ~bus.avn_waitrequest;
    assign push     = rvld_q[READ_LATENCY-1];
    assign pix_vld  = (count_q != '0);
    assign pop      = pix_vld & bus.pix_ready;

    assign bus.avn_read    = rd_req;
    assign bus.avn_address = addr_q;
    assign bus.pix_valid   = pix_vld;
    assign bus.pix_data    = pix_vld ? mem_q[rd_ptr_q] : '0;
    assign frame_busy      = (state_q != IDLE);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        issued_d = issued_q;
        rd_req   = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d  = FETCH;
                    addr_d   = AVN_AW'(BASE_ADDR);
                    issued_d = '0;
                end
            end
            FETCH: begin
                rd_req = space_ok && (issued_q < IW'(FRAME_WORDS));
                if (rd_req && !bus.avn_waitrequest) begin
                    addr_d   = addr_q + AVN_AW'(1);
                    issued_d = issued_q + IW'(1);
                    if (issued_q == IW'(FRAME_WORDS - 1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (outst_q == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        outst_d = outst_q;
        count_d = count_q;
        if (accept && !push)      outst_d = outst_q + CW'(1);
        else if (!accept && push) outst_d = outst_q - CW'(1);
        if (push && !pop)         count_d = count_q + CW'(1);
        else if (!push && pop)    count_d = count_q - CW'(1);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= IDLE;
            addr_q   <= AVN_AW'(BASE_ADDR);
            issued_q <= '0;
            outst_q  <= '0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            rvld_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            issued_q <= issued_d;
            outst_q  <= outst_d;
            count_q  <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            // Clearing this on reset is what discards in-flight returns.
            rvld_q[0] <= accept;
            for (int i = 1; i < READ_LATENCY; i++) rvld_q[i] <= rvld_q[i-1];
        end
    end

    always_ff @(posedge sys_clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.avn_readdata;
    end

`ifdef FB_READER_STATUS_EN
    logic underflow_q, overrun_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            underflow_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (bus.pix_ready && !pix_vld && frame_busy) underflow_q <= 1'b1;
            else if (status_clr)                          underflow_q <= 1'b0;
            if (frame_start && state_q != IDLE)          overrun_q   <= 1'b1;
            else if (status_clr)                          overrun_q   <= 1'b0;
        end
    end

    assign underflow = underflow_q;
    assign overrun   = overrun_q;
`endif
endmodule

// File: tb/tb_fb_read_master.sv
// Directed bench for fb_read_master: instance a (8-word frame, depth-4 FIFO) and instance b (4 words wrapping at 2^18).
// Slave model returns the low 16 address bits two cycles after acceptance.
module tb_fb_read_master;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic fs_a  = 1'b0;
    logic fs_b  = 1'b0;
    logic busy_a, busy_b;
`ifdef FB_READER_STATUS_EN
    logic clr_a = 1'b0;
    logic clr_b = 1'b0;
    logic und_a, ovr_a, und_b, ovr_b;
`endif
    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    fb_read_master_if #(.AW(18), .DW(16)) bus_a ();
    fb_read_master_if #(.AW(18), .DW(16)) bus_b ();

    fb_read_master #(.AVN_AW(18), .AVN_DW(16), .FRAME_WORDS(8), .BASE_ADDR(0),
                     .FIFO_DEPTH(4), .READ_LATENCY(2)) dut_a (
        .sys_clk(clk), .sys_rst_n(rst_n), .frame_start(fs_a), .frame_busy(busy_a),
`ifdef FB_READER_STATUS_EN
        .status_clr(clr_a), .underflow(und_a), .overrun(ovr_a),
`endif
        .bus(bus_a)
    );

    fb_read_master #(.AVN_AW(18), .AVN_DW(16), .FRAME_WORDS(4), .BASE_ADDR(262142),
                     .FIFO_DEPTH(16), .READ_LATENCY(2)) dut_b (
        .sys_clk(clk), .sys_rst_n(rst_n), .frame_start(fs_b), .frame_busy(busy_b),
`ifdef FB_READER_STATUS_EN
        .status_clr(clr_b), .underflow(und_b), .overrun(ovr_b),
`endif
        .bus(bus_b)
    );

    // Slave: readdata in cycle n reflects what was accepted in cycle n-2.
    logic [15:0] hist_a [8];
    logic [15:0] hist_b [8];
    initial begin : slave_model
        for (int i = 0; i < 8; i++) begin
            hist_a[i] = 16'hEEEE;
            hist_b[i] = 16'hEEEE;
        end
        bus_a.avn_readdata = 16'hEEEE;
        bus_b.avn_readdata = 16'hEEEE;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            #1;
            bus_a.avn_readdata = hist_a[(cyc + 6) % 8];
            bus_b.avn_readdata = hist_b[(cyc + 6) % 8];
            @(negedge clk);
            hist_a[cyc % 8] = (bus_a.avn_read && !bus_a.avn_waitrequest) ? bus_a.avn_address[15:0] : 16'hEEEE;
            hist_b[cyc % 8] = (bus_b.avn_read && !bus_b.avn_waitrequest) ? bus_b.avn_address[15:0] : 16'hEEEE;
        end
    end

    logic [17:0] acc_a [$];
    int          acc_cyc_a [$];
    logic [15:0] pop_a [$];
    int          pop_cyc_a [$];
    int          busy_last_a = 0;
    logic [17:0] acc_b [$];
    logic [15:0] pop_b [$];

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (bus_a.avn_read && !bus_a.avn_waitrequest) begin
                acc_a.push_back(bus_a.avn_address);
                acc_cyc_a.push_back(cyc);
            end
            if (bus_a.pix_valid && bus_a.pix_ready) begin
                pop_a.push_back(bus_a.pix_data);
                pop_cyc_a.push_back(cyc);
            end
            if (busy_a) busy_last_a = cyc;
            if (bus_b.avn_read && !bus_b.avn_waitrequest) acc_b.push_back(bus_b.avn_address);
            if (bus_b.pix_valid && bus_b.pix_ready) pop_b.push_back(bus_b.pix_data);
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_a();
        acc_a.delete();
        acc_cyc_a.delete();
        pop_a.delete();
        pop_cyc_a.delete();
    endtask

    task automatic start_a(output int c);
        fs_a = 1'b1;
        c = cyc;
        tick();
        fs_a = 1'b0;
    endtask

    task automatic wait_idle_a(input string tag);
        for (int i = 0; i < 200 && busy_a; i++) tick();
        check_val(tag, busy_a, 0);
    endtask

    // Checks a full 8-word frame on instance a: addresses and pixels both 0..7 in order.
    task automatic check_frame_a(input string tag);
        check_val({tag, "_nacc"}, acc_a.size(), 8);
        check_val({tag, "_npop"}, pop_a.size(), 8);
        for (int i = 0; i < 8 && i < acc_a.size(); i++)
            check_val($sformatf("%s_addr%0d", tag, i), acc_a[i], i);
        for (int i = 0; i < 8 && i < pop_a.size(); i++)
            check_val($sformatf("%s_pix%0d", tag, i), pop_a[i], i);
    endtask

    initial begin : main
        int c;
        int k;
        logic [17:0] exp_b [4];
        exp_b[0] = 18'h3FFFE; exp_b[1] = 18'h3FFFF; exp_b[2] = 18'h00000; exp_b[3] = 18'h00001;
        bus_a.avn_waitrequest = 1'b0;
        bus_a.pix_ready       = 1'b0;
        bus_b.avn_waitrequest = 1'b0;
        bus_b.pix_ready       = 1'b0;

        repeat (3) tick();
        @(negedge clk);
        check_val("rst_read",  bus_a.avn_read, 0);
        check_val("rst_addr",  bus_a.avn_address, 0);
        check_val("rst_addr_b", bus_b.avn_address, 18'h3FFFE);
        check_val("rst_valid", bus_a.pix_valid, 0);
        check_val("rst_data",  bus_a.pix_data, 0);
        check_val("rst_busy",  busy_a, 0);
`ifdef FB_READER_STATUS_EN
        check_val("rst_und", und_a, 0);
        check_val("rst_ovr", ovr_a, 0);
`endif
        tick();
        rst_n = 1'b1;
        tick();
        tick();

        // Zero-wait streaming, consumer always ready.
        bus_a.pix_ready = 1'b1;
        clear_a();
        start_a(c);
        wait_idle_a("t1_idle");
        check_frame_a("t1");
        for (int i = 0; i < 8 && i < acc_cyc_a.size(); i++)
            check_val($sformatf("t1_acc_cyc%0d", i), acc_cyc_a[i], c + 1 + i);
        if (pop_cyc_a.size() > 0) check_val("t1_first_pop_cyc", pop_cyc_a[0], c + 4);
        check_val("t1_busy_last", busy_last_a, c + 11);

        // Consumer stalled: reservation limits to FIFO_DEPTH reads.
        bus_a.pix_ready = 1'b0;
        clear_a();
        start_a(c);
        repeat (20) tick();
        check_val("t2_nacc_stall", acc_a.size(), 4);
        check_val("t2_read_stall", bus_a.avn_read, 0);
        check_val("t2_valid", bus_a.pix_valid, 1);
        check_val("t2_head", bus_a.pix_data, 0);
        check_val("t2_npop_stall", pop_a.size(), 0);
        bus_a.pix_ready = 1'b1;
        wait_idle_a("t2_idle");
        check_frame_a("t2");

        // Waitrequest for 5 cycles on the third read.
        clear_a();
        start_a(c);
        for (k = 0; k < 50 && !(bus_a.avn_read && bus_a.avn_address == 18'd2); k++) tick();
        check_val("t3_found", bus_a.avn_address, 2);
        bus_a.avn_waitrequest = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val($sformatf("t3_hold_read%0d", i), bus_a.avn_read, 1);
            check_val($sformatf("t3_hold_addr%0d", i), bus_a.avn_address, 2);
            tick();
        end
        bus_a.avn_waitrequest = 1'b0;
        wait_idle_a("t3_idle");
        check_frame_a("t3");
        if (acc_cyc_a.size() > 2) begin
            check_val("t3_first_cyc", acc_cyc_a[0], c + 1);
            check_val("t3_gap", acc_cyc_a[2] - acc_cyc_a[1], 6);
        end

        // Address wrap at the top of the address space.
        bus_b.pix_ready = 1'b1;
        fs_b = 1'b1;
        tick();
        fs_b = 1'b0;
        for (int i = 0; i < 200 && busy_b; i++) tick();
        check_val("t4_idle", busy_b, 0);
        check_val("t4_nacc", acc_b.size(), 4);
        check_val("t4_npop", pop_b.size(), 4);
        for (int i = 0; i < 4 && i < acc_b.size(); i++)
            check_val($sformatf("t4_addr%0d", i), acc_b[i], exp_b[i]);
        for (int i = 0; i < 4 && i < pop_b.size(); i++)
            check_val($sformatf("t4_pix%0d", i), pop_b[i], {14'd0, exp_b[i][15:0]});

        // Reset with two reads in flight; stale returns must never appear.
        clear_a();
        start_a(c);
        tick();
        tick();
        check_val("t5_nacc_pre", acc_a.size(), 2);
        rst_n = 1'b0;
        #1;
        check_val("t5_read", bus_a.avn_read, 0);
        check_val("t5_addr", bus_a.avn_address, 0);
        check_val("t5_valid", bus_a.pix_valid, 0);
        check_val("t5_data", bus_a.pix_data, 0);
        check_val("t5_busy", busy_a, 0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check_val("t5_stale_valid", bus_a.pix_valid, 0);
        check_val("t5_stale_npop", pop_a.size(), 0);
        check_val("t5_busy_after", busy_a, 0);
        clear_a();
        start_a(c);
        wait_idle_a("t5_idle");
        check_frame_a("t5");

`ifdef FB_READER_STATUS_EN
        check_val("t6_und_set", und_a, 1);
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        check_val("t6_und_clr", und_a, 0);
        check_val("t6_ovr_clr", ovr_a, 0);
        clear_a();
        start_a(c);
        tick();
        tick();
        fs_a = 1'b1;
        tick();
        fs_a = 1'b0;
        tick();
        check_val("t6_ovr_set", ovr_a, 1);
        check_val("t6_und_set2", und_a, 1);
        check_val("t6_busy", busy_a, 1);
        wait_idle_a("t6_idle");
        check_frame_a("t6");
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        check_val("t6_und_clr2", und_a, 0);
        check_val("t6_ovr_clr2", ovr_a, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
